imread_stream: RTL and testbench
================================

Name: imread_stream

Overview:
- Parametrised successor to the fixed 24-bit, 512x512 image reader.
- Scans a frame of IMG_W x IMG_H pixels out of an external synchronous-read pixel memory (1-cycle read latency).
- Emits the pixels as a valid/ready stream with start-of-frame and end-of-line markers.
- Supports single-shot or continuous frames, and tolerates downstream backpressure without losing or duplicating pixels.

Parameters:
- PIX_W, 24, pixel width in bits.
- IMG_W, 512, pixels per line (>=2).
- IMG_H, 512, lines per frame (>=1).
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- HBLANK, 8, idle cycles inserted after each line (used only with IMREAD_BLANK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- cont  in  1  sampled at frame end; 1 = immediately start the next frame.
- busy  out  1  high from start acceptance until the last pixel of the last frame is accepted.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address, row-major, 0 .. IMG_W*IMG_H-1.
- mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en.
- img_dout  out  PIX_W  pixel data.
- img_dout_vld  out  1  pixel valid.
- img_dout_rdy  in  1  downstream ready; a transfer occurs when vld && rdy.
- img_sof  out  1  high with pixel (0,0).
- img_eol  out  1  high with the last pixel of each line.
- frame_done  out  1  one-cycle pulse on the transfer of the last pixel of a frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are 0.
  - Counters (col, row, addr) are 0.
  - State is IDLE.
  - Skid buffer is emptied.
- States and transitions:
  - IDLE: start=1 -> RUN; busy=1 from the next cycle.
  - RUN: issue reads. After issuing the read at col=IMG_W-1: go to BLANK if the feature is enabled, otherwise stay in RUN on the next row.
  - BLANK: wait HBLANK cycles, then return to RUN.
  - After the read of the last pixel (addr = IMG_W*IMG_H-1) is issued, go to DRAIN.
  - DRAIN: wait until that pixel is transferred. Then frame_done=1. If cont=1, go to RUN with counters reset; otherwise go to IDLE and set busy=0 in the same cycle.
- start while busy is ignored.
- Read issue rule: mem_rd_en=1 only in RUN and only when (buffer occupancy + reads in flight) < 2. This guarantees no overflow under any rdy pattern.
- Output buffer: 2-entry FIFO. Each entry holds data, sof, and eol, tagged at issue time from col/row.
- img_dout_vld=1 whenever the FIFO is non-empty. Data, sof, and eol hold stable while vld && !rdy.
- Latency with rdy held at 1:
  - start sampled at edge T.
  - First mem_rd_en during cycle T+1.
  - First img_dout_vld during cycle T+2.
  - Throughput is 1 pixel/clock thereafter, with no bubbles inside a line (blanking disabled).
- Counters and address:
  - col wraps IMG_W-1 -> 0 and increments row.
  - mem_addr increments by 1 per read and wraps to 0 at frame end.
- Continuous frames: the first read of the next frame may be issued in the same cycle as frame_done, so there is no gap between frames.
- Reset asserted mid-frame: immediate return to IDLE. In-flight data is discarded and no frame_done is produced.

Optional Feature:
- Macro: IMREAD_BLANK_EN.
- Defined: the BLANK state exists and inserts HBLANK cycles with mem_rd_en=0 after each line's last read. The output stream therefore shows a gap of >=HBLANK cycles between the eol pixel and the next line's first pixel.
- Undefined: the BLANK state, its counter, and the HBLANK logic are not compiled; lines stream back-to-back.

Decomposition:
- Package imread_pkg holds:
  - state encoding localparams (IDLE, RUN, BLANK, DRAIN);
  - the FIFO entry width constant (PIX_W+2);
  - a function computing ADDR_W from IMG_W*IMG_H for elaboration checks.
- One sub-module, imread_skid_fifo: 2-entry FIFO with parameter DATA_W and ports push, data_in, pop, data_out, count.
- Address/counter logic and the FSM stay in the top-level module.

Test Plan:
- IMG_W=4, IMG_H=2, memory holds addr+0x100, rdy=1, start pulse:
  - 8 transfers, data 0x100..0x107;
  - sof on 0x100 only; eol on 0x103 and 0x107;
  - first vld 2 cycles after start;
  - frame_done with 0x107; busy falls the same cycle.
- Same setup, rdy toggling 1,0,0,1 pseudo-randomly (LFSR seed 0x5A):
  - exactly 8 transfers in order, no duplicates;
  - data stable while stalled; mem_rd_en never issued with occupancy+inflight=2.
- cont=1, two frames:
  - 16 contiguous transfers with rdy=1; second sof on the 9th pixel (0x100);
  - two frame_done pulses; busy continuous.
- start pulsed again mid-frame: ignored; sequence identical to scenario 1.
- rst_n low for 1 cycle after the 3rd transfer:
  - all outputs 0 next cycle, no frame_done;
  - a fresh start yields a full frame beginning at 0x100.
- With IMREAD_BLANK_EN and HBLANK=3: a gap of >=3 cycles with vld=0 between 0x103 and 0x104; pixel order unchanged.

Source files
------------

// File: rtl/imread_pkg.sv
// Shared definitions for the imread_stream frame reader: state encoding,
// output-buffer entry layout and an address-width helper for parameter checks.
package imread_pkg;

  // State encoding, kept as named constants so debug tools can decode them.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_BLANK_ENC = 2'd2;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    RUN   = ST_RUN_ENC,
    BLANK = ST_BLANK_ENC,
    DRAIN = ST_DRAIN_ENC
  } state_e;

  // Each buffer entry is {pixel, sof, eol}.
  localparam int unsigned TAG_W       = 32'd2;
  localparam int unsigned DEF_PIX_W   = 32'd24;
  localparam int unsigned DEF_ENTRY_W = DEF_PIX_W + TAG_W;

  // Width of one buffer entry for a given pixel width.
  function automatic int unsigned entry_width(input int unsigned pix_w);
    return pix_w + TAG_W;
  endfunction

  // Smallest address width (at least 1) that can index n_pix locations.
  function automatic int unsigned addr_width_for(input longint unsigned n_pix);
    int unsigned w;
    w = 32'd1;
    while ((w < 32'd63) && ((64'd1 << w) < n_pix)) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/imread_skid_fifo.sv
// Two-entry FIFO that absorbs pixels returning from memory while the
// downstream consumer stalls. Push into a full FIFO and pop from an empty
// FIFO are ignored so a misbehaving caller cannot corrupt the pointers.
module imread_skid_fifo #(
  parameter int unsigned DATA_W = 32'd26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  // Next-state computation for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    push_ok_s = push & (count_q != 2'd2);
    pop_ok_s  = pop & (count_q != 2'd0);
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= {DATA_W{1'b0}};
      mem_q[1] <= {DATA_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/imread_stream.sv
// imread_stream: scans an IMG_W x IMG_H frame out of a synchronous-read pixel
// memory (1-cycle latency) and emits it as a valid/ready stream with sof/eol.
// Optional feature macro IMREAD_BLANK_EN: inserts HBLANK idle read cycles
// after each line. Without it, lines stream back-to-back.
//
// A word returning from memory is presented directly on the output when the
// buffer is empty (giving the two-cycle start-to-valid latency); if it is not
// accepted it is captured in the 2-entry FIFO and re-presented unchanged.
// Reads are issued only while (FIFO occupancy + read in flight) < 2, so the
// FIFO can never overflow regardless of the ready pattern.
module imread_stream
  import imread_pkg::*;
#(
  parameter int unsigned PIX_W  = 32'd24,
  parameter int unsigned IMG_W  = 32'd512,
  parameter int unsigned IMG_H  = 32'd512,
  parameter int unsigned ADDR_W = 32'd18,
  parameter int unsigned HBLANK = 32'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  img_dout,
  output logic              img_dout_vld,
  input  logic              img_dout_rdy,
  output logic              img_sof,
  output logic              img_eol,
  output logic              frame_done
);

  localparam int unsigned ENTRY_W = entry_width(PIX_W);
  localparam int unsigned COL_W   = (IMG_W > 32'd1) ? $clog2(IMG_W) : 32'd1;
  localparam int unsigned ROW_W   = (IMG_H > 32'd1) ? $clog2(IMG_H) : 32'd1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 32'd1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 32'd1);

  // Parameter sanity checks at elaboration.
  if (ADDR_W < addr_width_for(64'(IMG_W) * 64'(IMG_H))) begin : g_bad_addr_w
    $error("imread_stream: ADDR_W too small for IMG_W*IMG_H");
  end
  if (IMG_W < 32'd2) begin : g_bad_img_w
    $error("imread_stream: IMG_W must be at least 2");
  end
  if (HBLANK < 32'd1) begin : g_bad_hblank
    $error("imread_stream: HBLANK must be at least 1");
  end

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                infl_q, infl_d;
  logic [1:0]          tag_q, tag_d;

`ifdef IMREAD_BLANK_EN
  localparam int unsigned BLK_W = (HBLANK > 32'd1) ? $clog2(HBLANK) : 32'd1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HBLANK - 32'd1);
  logic [BLK_W-1:0]    blank_cnt_q, blank_cnt_d;
`endif

  logic [ENTRY_W-1:0]  head_s;
  logic                vld_s;
  logic                xfer_s;
  logic                fifo_push_s;
  logic                fifo_pop_s;
  logic [ENTRY_W-1:0]  fifo_din_s;
  logic [ENTRY_W-1:0]  fifo_dout_s;
  logic [1:0]          fifo_count_s;
  logic                space_s;
  logic                last_xfer_s;
  logic                rd_en_s;
  logic                busy_s;
  logic                frame_done_s;

  imread_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push_s),
    .data_in  (fifo_din_s),
    .pop      (fifo_pop_s),
    .data_out (fifo_dout_s),
    .count    (fifo_count_s)
  );

  // Output selection: FIFO head first, else the word arriving from memory.
  always_comb begin
    head_s     = {ENTRY_W{1'b0}};
    vld_s      = 1'b0;
    fifo_din_s = {mem_rdata, tag_q};
    if (fifo_count_s != 2'd0) begin
      head_s = fifo_dout_s;
      vld_s  = 1'b1;
    end else if (infl_q) begin
      head_s = fifo_din_s;
      vld_s  = 1'b1;
    end else begin
      head_s = {ENTRY_W{1'b0}};
      vld_s  = 1'b0;
    end
    xfer_s      = vld_s & img_dout_rdy;
    fifo_pop_s  = (fifo_count_s != 2'd0) & img_dout_rdy;
    fifo_push_s = infl_q & ~((fifo_count_s == 2'd0) & img_dout_rdy);
  end

  // FSM next state, read issue and scan counters.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    infl_d       = 1'b0;
    tag_d        = tag_q;
    rd_en_s      = 1'b0;
    busy_s       = 1'b0;
    frame_done_s = 1'b0;
`ifdef IMREAD_BLANK_EN
    blank_cnt_d  = blank_cnt_q;
`endif
    space_s     = ({1'b0, fifo_count_s} + {2'b00, infl_q}) < 3'd2;
    // In DRAIN only the frame's final pixel can still carry eol (IMG_W >= 2).
    last_xfer_s = (state_q == DRAIN) & xfer_s & head_s[0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy_s  = 1'b1;
        rd_en_s = space_s;
      end
`ifdef IMREAD_BLANK_EN
      BLANK: begin
        busy_s = 1'b1;
        if (blank_cnt_q == BLK_LAST) begin
          blank_cnt_d = {BLK_W{1'b0}};
          state_d     = RUN;
        end else begin
          blank_cnt_d = blank_cnt_q + BLK_W'(1'b1);
          state_d     = BLANK;
        end
      end
`endif
      DRAIN: begin
        busy_s = 1'b1;
        if (last_xfer_s) begin
          frame_done_s = 1'b1;
          if (cont) begin
            // Counters already wrapped: next frame's first read goes out now.
            state_d = RUN;
            rd_en_s = space_s;
          end else begin
            state_d = IDLE;
            busy_s  = 1'b0;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rd_en_s) begin
      infl_d = 1'b1;
      tag_d  = {(col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}}),
                col_q == COL_LAST};
      if (col_q == COL_LAST) begin
        col_d = {COL_W{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d   = {ROW_W{1'b0}};
          addr_d  = {ADDR_W{1'b0}};
          state_d = DRAIN;
        end else begin
          row_d  = row_q + ROW_W'(1'b1);
          addr_d = addr_q + ADDR_W'(1'b1);
`ifdef IMREAD_BLANK_EN
          state_d = BLANK;
`else
          state_d = RUN;
`endif
        end
      end else begin
        col_d   = col_q + COL_W'(1'b1);
        addr_d  = addr_q + ADDR_W'(1'b1);
        state_d = RUN;
      end
    end else begin
      infl_d = 1'b0;
    end
  end

  // State, counters and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      infl_q  <= 1'b0;
      tag_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      infl_q  <= infl_d;
      tag_q   <= tag_d;
    end
  end

`ifdef IMREAD_BLANK_EN
  // Blanking interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt_q <= {BLK_W{1'b0}};
    end else begin
      blank_cnt_q <= blank_cnt_d;
    end
  end
`endif

  assign busy         = busy_s;
  assign mem_rd_en    = rd_en_s;
  assign mem_addr     = addr_q;
  assign img_dout     = head_s[ENTRY_W-1:2];
  assign img_sof      = head_s[1];
  assign img_eol      = head_s[0];
  assign img_dout_vld = vld_s;
  assign frame_done   = frame_done_s;

endmodule

// File: tb/tb_imread_stream.sv
// Directed testbench for imread_stream with a 4x2 frame and a memory model
// returning addr+0x100. A negedge monitor records transfers and events; all
// comparisons go through check_eq.
module tb_imread_stream;

  localparam int PIX_W  = 24;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 3;
  localparam int HBLANK = 3;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              img_dout_rdy = 1'b1;
  logic              busy, mem_rd_en, img_dout_vld, img_sof, img_eol, frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic [PIX_W-1:0]  img_dout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory model, one cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 24'h000100 + {21'd0, mem_addr};
  end

  imread_stream #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .HBLANK(HBLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .img_dout(img_dout), .img_dout_vld(img_dout_vld), .img_dout_rdy(img_dout_rdy),
    .img_sof(img_sof), .img_eol(img_eol), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor state
  logic              clr_req = 1'b0;
  logic              rdy_mode = 1'b0;
  logic [7:0]        lfsr = 8'h5A;
  logic [PIX_W-1:0]  xd[$];
  logic [1:0]        xt[$];
  int                xc[$];
  int start_cyc = -1, first_rd_cyc = -1, first_vld_cyc = -1;
  int done_cnt = 0, done_cyc = -1, busy_cnt = 0;
  int rd_viol = 0, stab_err = 0, stall_cnt = 0, outstanding = 0;
  logic done_busy = 1'b1, prev_stall = 1'b0;
  logic [PIX_W+1:0] prev_out = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (clr_req) begin
        xd.delete(); xt.delete(); xc.delete();
        start_cyc = -1; first_rd_cyc = -1; first_vld_cyc = -1;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; done_busy = 1'b1;
        rd_viol = 0; stab_err = 0; stall_cnt = 0; outstanding = 0;
        prev_stall = 1'b0;
      end else begin
        if (start && start_cyc < 0) start_cyc = cyc;
        if (mem_rd_en) begin
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          if (outstanding >= 2) rd_viol++;
        end
        if (img_dout_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (prev_stall && !(img_dout_vld && ({img_dout, img_sof, img_eol} == prev_out)))
          stab_err++;
        prev_stall = img_dout_vld && !img_dout_rdy;
        prev_out   = {img_dout, img_sof, img_eol};
        if (prev_stall) stall_cnt++;
        if (img_dout_vld && img_dout_rdy) begin
          xd.push_back(img_dout);
          xt.push_back({img_sof, img_eol});
          xc.push_back(cyc);
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
        if (busy) busy_cnt++;
        if (!rst_n) outstanding = 0;
        else outstanding = outstanding + int'(mem_rd_en) - int'(img_dout_vld && img_dout_rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      img_dout_rdy = lfsr[0];
    end
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) tick();
  endtask

  function automatic logic [PIX_W-1:0] pix_at(input int i);
    return (i < xd.size()) ? xd[i] : 24'hFFFFFF;
  endfunction

  function automatic logic [1:0] tag_at(input int i);
    return (i < xt.size()) ? xt[i] : 2'b11;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < xc.size()) ? xc[i] : -1000;
  endfunction

  // Pixel values and sof/eol tags for n transfers of back-to-back frames.
  task automatic check_frame(input string pfx, input int n);
    check_eq({pfx, "_xfer_count"}, xd.size(), n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = i % NPIX;
      check_eq({pfx, "_pixel"}, pix_at(i), 24'h000100 + k);
      check_eq({pfx, "_sof_eol"}, tag_at(i), {k == 0, (k % IMG_W) == IMG_W - 1});
    end
  endtask

  task automatic check_single(input string pfx);
    check_frame(pfx, NPIX);
    check_eq({pfx, "_rd_latency"}, first_rd_cyc - start_cyc, 1);
    check_eq({pfx, "_vld_latency"}, first_vld_cyc - start_cyc, 2);
    check_eq({pfx, "_done_count"}, done_cnt, 1);
    check_eq({pfx, "_done_on_last"}, done_cyc, cyc_at(NPIX - 1));
    check_eq({pfx, "_busy_at_done"}, done_busy, 0);
    check_eq({pfx, "_busy_cycles"}, busy_cnt, done_cyc - start_cyc - 1);
    check_eq({pfx, "_rd_rule"}, rd_viol, 0);
`ifdef IMREAD_BLANK_EN
    check_eq({pfx, "_hblank_gap"}, (cyc_at(4) - cyc_at(3)) > HBLANK, 1);
`else
    check_eq({pfx, "_no_bubble"}, cyc_at(NPIX - 1) - cyc_at(0), NPIX - 1);
`endif
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("reset_outputs", {busy, mem_rd_en, mem_addr, img_dout, img_dout_vld,
                               img_sof, img_eol, frame_done}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single frame, rdy held high
    clear_stats();
    pulse_start();
    wait_done(1, 100);
    repeat (4) tick();
    check_single("s1");

    // 2: pseudo-random backpressure
    rdy_mode = 1'b1;
    lfsr = 8'h5A;
    clear_stats();
    pulse_start();
    wait_done(1, 400);
    rdy_mode = 1'b0;
    img_dout_rdy = 1'b1;
    repeat (4) tick();
    check_frame("s2", NPIX);
    check_eq("s2_done_count", done_cnt, 1);
    check_eq("s2_rd_rule", rd_viol, 0);
    check_eq("s2_stable_when_stalled", stab_err, 0);
    check_eq("s2_stalls_seen", stall_cnt != 0, 1);

    // 3: two continuous frames
    cont = 1'b1;
    clear_stats();
    pulse_start();
    wait_done(1, 100);
    cont = 1'b0;
    wait_done(2, 100);
    repeat (4) tick();
    check_frame("s3", 2 * NPIX);
    check_eq("s3_done_count", done_cnt, 2);
    check_eq("s3_busy_cycles", busy_cnt, done_cyc - start_cyc - 1);
    check_eq("s3_busy_at_last_done", done_busy, 0);
    check_eq("s3_rd_rule", rd_viol, 0);
`ifndef IMREAD_BLANK_EN
    check_eq("s3_contiguous", cyc_at(2 * NPIX - 1) - cyc_at(0), 2 * NPIX - 1);
`endif

    // 4: start pulsed again mid-frame is ignored
    clear_stats();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_done(1, 100);
    repeat (4) tick();
    check_single("s4");

    // 5: reset after the third transfer, then a fresh frame
    clear_stats();
    pulse_start();
    for (int i = 0; i < 100 && xd.size() < 3; i++) tick();
    check_eq("s5_three_xfers", xd.size(), 3);
    rst_n = 1'b0;
    #2;
    check_eq("s5_reset_outputs", {busy, mem_rd_en, mem_addr, img_dout, img_dout_vld,
                                  img_sof, img_eol, frame_done}, 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("s5_no_done", done_cnt, 0);
    check_eq("s5_idle_after_reset", busy, 0);
    clear_stats();
    pulse_start();
    wait_done(1, 100);
    repeat (4) tick();
    check_single("s5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
